// File: rtl/riscv_mc_if.sv
// Control-side bundle of the multicycle RV32I core: IR fields, ALU flag and memory
// handshake inputs, plus every datapath enable/select the control FSM produces.
interface riscv_mc_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       illegal;
  logic [3:0] state;

  // Handshake: mem_req/mem_we/adr_src are held stable from the first cycle the
  // request is raised until the rising edge on which mem_ready=1 completes it.
  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src, illegal, state
  );
endinterface

// File: rtl/riscv_mc_control.sv
// Main control FSM of the multicycle RV32I core: walks fetch/decode/execute/memory/
// writeback and drives all datapath enables and selects from state and IR fields.
module riscv_mc_control (
  input  logic         clk,
  input  logic         rst_n,
  riscv_mc_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c;
  logic       adr_src_c;
  logic [1:0] src_a_c, src_b_c, result_src_c, imm_src_c;
  logic [2:0] alu_ctrl_c;

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'd1;
      OP_BEQ:  return 2'd2;
      OP_JAL:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    src_a_c      = 2'd0;
    src_b_c      = 2'd0;
    alu_ctrl_c   = 3'b000;
    result_src_c = 2'd0;
    imm_src_c    = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        src_b_c      = 2'd2;
        result_src_c = 2'd2;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_c   = 2'd1;
        src_b_c   = 2'd1;
        imm_src_c = imm_of(bus.opcode);
        case (bus.opcode)
          OP_LW, OP_SW: state_d = (bus.funct3 == 3'b010) ? S_MEMADR : S_TRAP;
          OP_R:         state_d = alu_f3_ok(bus.funct3) ? S_EXEC_R : S_TRAP;
          OP_I:         state_d = alu_f3_ok(bus.funct3) ? S_EXEC_I : S_TRAP;
          OP_BEQ:       state_d = (bus.funct3 == 3'b000) ? S_BEQ : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a_c   = 2'd2;
        src_b_c   = 2'd1;
        // The immediate feeds the ALU here too, so keep the S/I format selected.
        imm_src_c = imm_of(bus.opcode);
        state_d   = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'd1;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        src_a_c    = 2'd2;
        alu_ctrl_c = alu_dec(bus.funct3, bus.funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a_c    = 2'd2;
        src_b_c    = 2'd1;
        imm_src_c  = imm_of(bus.opcode);
        alu_ctrl_c = alu_dec(bus.funct3, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        src_a_c    = 2'd2;
        alu_ctrl_c = 3'b001;
        pc_write_c = bus.zero;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC <- target latched in DECODE while the ALU forms OldPC+4 for rd.
        src_a_c    = 2'd1;
        src_b_c    = 2'd2;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase

    if (state_d == S_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Enables are gated by rst_n so a reset mid-access withdraws them at once.
  assign bus.mem_req    = mem_req_c & rst_n;
  assign bus.mem_we     = mem_we_c & rst_n;
  assign bus.ir_write   = ir_write_c & rst_n;
  assign bus.pc_write   = pc_write_c & rst_n;
  assign bus.reg_write  = reg_write_c & rst_n;
  assign bus.adr_src    = adr_src_c;
  assign bus.alu_src_a  = src_a_c;
  assign bus.alu_src_b  = src_b_c;
  assign bus.alu_ctrl   = alu_ctrl_c;
  assign bus.result_src = result_src_c;
  assign bus.imm_src    = imm_src_c;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

endmodule
